// File: rtl/cdb_pkg.sv
// Package cdb_pkg: constants and small helpers shared by the common-data-bus (CDB)
// arbiter slice.
//   TAG_NONE        tag value meaning "no destination"; never broadcast
//   TAG_W_DEF       default ROB tag width
//   DATA_W_DEF      default result data width
//   NUM_SRC_DEF     default number of result producers
//   BUF_DEPTH_DEF   default per-source FIFO depth
//   SRC_ALU/SRC_MEM source index of the ALU and of the memory unit
//   count_ones4     population count of up to four request bits
package cdb_pkg;

  localparam int TAG_NONE      = 0;
  localparam int TAG_W_DEF     = 3;
  localparam int DATA_W_DEF    = 32;
  localparam int NUM_SRC_DEF   = 2;
  localparam int BUF_DEPTH_DEF = 2;

  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;

  // Number of set bits in a 4-bit vector; NUM_SRC never exceeds four.
  function automatic logic [2:0] count_ones4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Interface cdb_arbiter_if: producer-side handshake and CDB broadcast bundle.
//   src_valid  per-source result valid            (producer -> arbiter)
//   src_ready  per-source FIFO can accept         (arbiter -> producer)
//   src_tag    packed tags, source i at [i*TAG_W +: TAG_W]
//   src_data   packed data, source i at [i*DATA_W +: DATA_W]
//   cdb_valid  broadcast valid                    (arbiter -> snoopers)
//   cdb_tag    broadcast tag, 0 when cdb_valid=0
//   cdb_data   broadcast data
//   cdb_src    index of the winning source
// Modports: master = producers/snoopers side, slave = arbiter side.
interface cdb_arbiter_if
  import cdb_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
);

  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*TAG_W-1:0]  src_tag;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;
  logic [SRC_W-1:0]          cdb_src;

  modport master (
    output src_valid, src_tag, src_data,
    input  src_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  modport slave (
    input  src_valid, src_tag, src_data,
    output src_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

endinterface

// File: rtl/cdb_src_fifo.sv
// Module cdb_src_fifo: private result FIFO of one CDB producer.
//   clk        clock, posedge
//   rst        synchronous active-low reset, empties the FIFO
//   flush      empties the FIFO; a push in the same cycle is dropped
//   push       write push_data at the tail (ignored when full)
//   push_data  {tag,data} entry
//   pop        remove the head (ignored when empty)
//   head       current head entry, valid while empty=0
//   empty      no entries stored (from registered count)
//   full       BUF_DEPTH entries stored (from registered count)
module cdb_src_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == '0);
  assign full      = (count_r == CNT_W'(DEPTH));
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign head      = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (rst && !flush && do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Module cdb_arbiter: shares one registered common data bus between NUM_SRC producers.
// Each producer feeds a private cdb_src_fifo; a round-robin pointer picks one non-empty
// FIFO per cycle and its head is broadcast on the next edge. Tag 0 is accepted but dropped.
//   clk             clock, posedge
//   rst             synchronous active-low reset (priority over flush)
//   flush           mispredict flush: drops buffered results and this cycle's pushes
//   bus             cdb_arbiter_if.slave: src_valid/ready/tag/data in, cdb_* out
//   stat_conflicts  (only with CDB_STATS_EN) wrapping count of cycles with >=2 non-empty FIFOs
// Optional feature macro: CDB_STATS_EN.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_SRC   = NUM_SRC_DEF,
  parameter int TAG_W     = TAG_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
`ifdef CDB_STATS_EN
  output logic [31:0]  stat_conflicts,
`endif
  cdb_arbiter_if.slave bus
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int ENT_W = TAG_W + DATA_W;

  logic [NUM_SRC-1:0] ready_s;
  logic [NUM_SRC-1:0] push_s;
  logic [NUM_SRC-1:0] pop_s;
  logic [NUM_SRC-1:0] empty_s;
  logic [NUM_SRC-1:0] full_s;
  logic [ENT_W-1:0]   head_s [NUM_SRC];

  logic               found_s;
  logic [SRC_W-1:0]   winner_s;
  logic [ENT_W-1:0]   win_head_s;
  logic [SRC_W-1:0]   rr_next_s;

  logic [SRC_W-1:0]   rr_ptr_r;
  logic               cdb_valid_r;
  logic [TAG_W-1:0]   cdb_tag_r;
  logic [DATA_W-1:0]  cdb_data_r;
  logic [SRC_W-1:0]   cdb_src_r;

  // Ready comes from registered occupancy only, so a full FIFO being popped still reads 0.
  assign ready_s       = {NUM_SRC{rst}} & ~full_s;
  assign bus.src_ready = ready_s;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    // A zero tag completes the handshake but never enters the FIFO.
    assign push_s[i] = bus.src_valid[i] & ready_s[i] &
                       (bus.src_tag[i*TAG_W +: TAG_W] != TAG_W'(TAG_NONE));

    cdb_src_fifo #(
      .W     (ENT_W),
      .DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push_s[i]),
      .push_data ({bus.src_tag[i*TAG_W +: TAG_W], bus.src_data[i*DATA_W +: DATA_W]}),
      .pop       (pop_s[i]),
      .head      (head_s[i]),
      .empty     (empty_s[i]),
      .full      (full_s[i])
    );
  end

  // Round-robin winner: first non-empty FIFO scanning upward from rr_ptr, wrapping.
  always_comb begin
    int sum;
    int idx;
    found_s    = 1'b0;
    winner_s   = '0;
    win_head_s = '0;
    sum        = 0;
    idx        = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      sum = int'(rr_ptr_r) + k;
      idx = (sum >= NUM_SRC) ? (sum - NUM_SRC) : sum;
      if (!found_s && !empty_s[idx]) begin
        found_s    = 1'b1;
        winner_s   = SRC_W'(idx);
        win_head_s = head_s[idx];
      end else begin
        found_s    = found_s;
      end
    end
  end

  // Pop strobe for the winner and the pointer value that follows it.
  always_comb begin
    if (found_s) begin
      pop_s = {{(NUM_SRC-1){1'b0}}, 1'b1} << winner_s;
    end else begin
      pop_s = '0;
    end
    if (winner_s == SRC_W'(NUM_SRC - 1)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = winner_s + SRC_W'(1);
    end
  end

  // CDB output registers and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_r    <= '0;
      cdb_valid_r <= 1'b0;
      cdb_tag_r   <= '0;
      cdb_data_r  <= '0;
      cdb_src_r   <= '0;
    end else if (flush) begin
      // Pointer deliberately kept so fairness continues across the flush.
      cdb_valid_r <= 1'b0;
      cdb_tag_r   <= '0;
    end else if (found_s) begin
      rr_ptr_r    <= rr_next_s;
      cdb_valid_r <= 1'b1;
      cdb_tag_r   <= win_head_s[ENT_W-1 -: TAG_W];
      cdb_data_r  <= win_head_s[DATA_W-1:0];
      cdb_src_r   <= winner_s;
    end else begin
      cdb_valid_r <= 1'b0;
      cdb_tag_r   <= '0;
    end
  end

  assign bus.cdb_valid = cdb_valid_r;
  assign bus.cdb_tag   = cdb_tag_r;
  assign bus.cdb_data  = cdb_data_r;
  assign bus.cdb_src   = cdb_src_r;

`ifdef CDB_STATS_EN
  logic [3:0]  nonempty4_s;
  logic        conflict_s;
  logic [31:0] conflicts_r;

  // Conflict detect: two or more producers waiting in the same cycle.
  always_comb begin
    nonempty4_s              = 4'b0000;
    nonempty4_s[NUM_SRC-1:0] = ~empty_s;
    conflict_s               = (count_ones4(nonempty4_s) >= 3'd2);
  end

  // Conflict counter; survives flush, wraps at 2^32.
  always_ff @(posedge clk) begin
    if (!rst) begin
      conflicts_r <= 32'd0;
    end else if (conflict_s) begin
      conflicts_r <= conflicts_r + 32'd1;
    end else begin
      conflicts_r <= conflicts_r;
    end
  end

  assign stat_conflicts = conflicts_r;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench tb_cdb_arbiter: directed scenarios followed by randomized traffic, all
// checked cycle by cycle against a queue-based reference model of the CDB arbiter.
// Honours CDB_STATS_EN (checks stat_conflicts when defined).
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int NS    = 2;
  localparam int TW    = 3;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic clk;
  logic rst;
  logic flush;
`ifdef CDB_STATS_EN
  logic [31:0] stat_conflicts;
`endif

  cdb_arbiter_if #(.NUM_SRC(NS), .TAG_W(TW), .DATA_W(DW)) bus ();

  cdb_arbiter #(
    .NUM_SRC   (NS),
    .TAG_W     (TW),
    .DATA_W    (DW),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
`ifdef CDB_STATS_EN
    .stat_conflicts (stat_conflicts),
`endif
    .bus            (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: one queue of {tag,data} per source plus round-robin pointer.
  logic [TW+DW-1:0] mq [NS][$];
  int               rr;
  logic             ev;
  logic [TW-1:0]    et;
  logic [DW-1:0]    ed;
  int               es;
  logic [31:0]      est;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, predict the next rising edge, check after it.
  task automatic cycle(input logic r, input logic f, input logic [NS-1:0] v,
                       input logic [NS*TW-1:0] t, input logic [NS*DW-1:0] d);
    logic [NS-1:0] rdy;
    int            w;
    int            nonempty;
    int            idx;
    rst             = r;
    flush           = f;
    bus.src_valid   = v;
    bus.src_tag     = t;
    bus.src_data    = d;
    #1;
    nonempty = 0;
    for (int i = 0; i < NS; i++) begin
      rdy[i] = r && (mq[i].size() != DEPTH);
      if (mq[i].size() != 0) nonempty++;
    end
    check_val("src_ready", 64'(bus.src_ready), 64'(rdy));
    if (!r) begin
      for (int i = 0; i < NS; i++) mq[i].delete();
      rr = 0; ev = 1'b0; et = '0; ed = '0; es = 0; est = 32'd0;
    end else begin
      if (nonempty >= 2) est = est + 32'd1;
      if (f) begin
        for (int i = 0; i < NS; i++) mq[i].delete();
        ev = 1'b0; et = '0;
      end else begin
        w = -1;
        for (int k = 0; k < NS; k++) begin
          idx = (rr + k) % NS;
          if (w < 0 && mq[idx].size() != 0) w = idx;
        end
        if (w >= 0) begin
          {et, ed} = mq[w].pop_front();
          ev = 1'b1; es = w; rr = (w + 1) % NS;
        end else begin
          ev = 1'b0; et = '0;
        end
        for (int i = 0; i < NS; i++)
          if (v[i] && rdy[i] && t[i*TW +: TW] != TW'(TAG_NONE))
            mq[i].push_back({t[i*TW +: TW], d[i*DW +: DW]});
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_val("cdb_valid", 64'(bus.cdb_valid), 64'(ev));
    check_val("cdb_tag",   64'(bus.cdb_tag),   64'(et));
    check_val("cdb_data",  64'(bus.cdb_data),  64'(ed));
    check_val("cdb_src",   64'(bus.cdb_src),   64'(es));
`ifdef CDB_STATS_EN
    check_val("stat_conflicts", 64'(stat_conflicts), 64'(est));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 2'b00, '0, '0);
  endtask

  initial begin
    logic [NS-1:0]    v;
    logic [NS*TW-1:0] t;
    logic [NS*DW-1:0] d;
    rr = 0; ev = 1'b0; et = '0; ed = '0; es = 0; est = 32'd0;
    rst = 1'b0; flush = 1'b0;
    bus.src_valid = '0; bus.src_tag = '0; bus.src_data = '0;

    // Reset held with both sources asserting valid.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 2'b11, {3'd2, 3'd1}, {32'h2222, 32'h1111});
    idle(1);
    check_val("ready_after_reset", 64'(bus.src_ready), 64'd3);

    // Single result from the ALU.
    cycle(1'b1, 1'b0, 2'b01, {3'd0, 3'd3}, {32'h0, 32'h1234});
    idle(1);
    check_val("single_tag",  64'(bus.cdb_tag),  64'd3);
    check_val("single_data", 64'(bus.cdb_data), 64'h1234);
    idle(1);
    check_val("single_gone", 64'(bus.cdb_valid), 64'd0);

    // Reset to put rr_ptr at 0, then simultaneous pushes.
    cycle(1'b0, 1'b0, 2'b00, '0, '0);
    cycle(1'b1, 1'b0, 2'b11, {3'd2, 3'd1}, {32'hB0B0, 32'hA0A0});
    idle(1);
    check_val("conflict_first", 64'(bus.cdb_tag), 64'd1);
    idle(1);
    check_val("conflict_second", 64'(bus.cdb_tag), 64'd2);
    idle(1);

    // Memory unit pushes three tags while the ALU streams every cycle.
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 1'b0, {(i < 3) ? 1'b1 : 1'b0, 1'b1},
            {TW'(i + 4 > 7 ? 7 : i + 4), TW'((i % 7) + 1)},
            {32'h5000 + 32'(i), 32'h4000 + 32'(i)});
    idle(6);

    // Tag zero is accepted and dropped.
    cycle(1'b1, 1'b0, 2'b01, {3'd0, 3'd0}, {32'h0, 32'hDEAD});
    idle(1);
    check_val("tag0_no_beat", 64'(bus.cdb_valid), 64'd0);

    // Fill both FIFOs, flush, then a fresh push.
    cycle(1'b1, 1'b0, 2'b11, {3'd2, 3'd1}, {32'h12, 32'h11});
    cycle(1'b1, 1'b0, 2'b11, {3'd4, 3'd3}, {32'h14, 32'h13});
    cycle(1'b1, 1'b0, 2'b11, {3'd6, 3'd5}, {32'h16, 32'h15});
    cycle(1'b1, 1'b1, 2'b11, {3'd7, 3'd7}, {32'h77, 32'h77});
    check_val("flush_valid", 64'(bus.cdb_valid), 64'd0);
    idle(2);
    cycle(1'b1, 1'b0, 2'b01, {3'd0, 3'd5}, {32'h0, 32'h5555});
    idle(1);
    check_val("post_flush_tag", 64'(bus.cdb_tag), 64'd5);
    idle(2);

    // Randomized traffic with occasional flush and reset.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NS; i++) begin
        v[i]           = ($urandom_range(0, 3) != 0);
        t[i*TW +: TW]  = TW'($urandom_range(0, 7));
        d[i*DW +: DW]  = $urandom;
      end
      cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 29) == 0), v, t, d);
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
